// File: rtl/motion_ipif_master_if.sv
// Command/response and IPIF bus signal bundle for motion_ipif_master.
// master: the initiator's view; slave: the command source plus user_logic side.
interface motion_ipif_master_if #(
  parameter int unsigned C_NUM_CE = 32,
  parameter int unsigned C_IDX_W  = 5
);
  logic                  Cmd_Valid;
  logic                  Cmd_Ready;
  logic                  Cmd_RNW;
  logic [C_IDX_W-1:0]    Cmd_Index;
  logic [0:31]           Cmd_Data;
  logic [0:3]            Cmd_BE;

  logic                  Rsp_Valid;
  logic [0:31]           Rsp_Data;
  logic                  Rsp_Error;
  logic                  Rsp_Timeout;
  logic                  Busy;

  logic [0:31]           Bus2IP_Addr;
  logic [0:0]            Bus2IP_CS;
  logic                  Bus2IP_RNW;
  logic [0:31]           Bus2IP_Data;
  logic [0:3]            Bus2IP_BE;
  logic [0:C_NUM_CE-1]   Bus2IP_RdCE;
  logic [0:C_NUM_CE-1]   Bus2IP_WrCE;

  logic [0:31]           IP2Bus_Data;
  logic                  IP2Bus_RdAck;
  logic                  IP2Bus_WrAck;
  logic                  IP2Bus_Error;

  modport master (
    input  Cmd_Valid, Cmd_RNW, Cmd_Index, Cmd_Data, Cmd_BE,
    output Cmd_Ready,
    output Rsp_Valid, Rsp_Data, Rsp_Error, Rsp_Timeout, Busy,
    output Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
    output Bus2IP_RdCE, Bus2IP_WrCE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    output Cmd_Valid, Cmd_RNW, Cmd_Index, Cmd_Data, Cmd_BE,
    input  Cmd_Ready,
    input  Rsp_Valid, Rsp_Data, Rsp_Error, Rsp_Timeout, Busy,
    input  Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
    input  Bus2IP_RdCE, Bus2IP_WrCE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/motion_ipif_master.sv
// Register-access initiator for the motion core IPIF slave port.
// Turns single-entry commands into Bus2IP_* cycles with one-hot RdCE/WrCE,
// waits for the matching ack or a timeout, and returns a one-cycle response.
module motion_ipif_master #(
  parameter int unsigned C_NUM_CE   = 32,
  parameter int unsigned C_IDX_W    = 5,
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter int unsigned C_TIMEOUT  = 16
) (
  input logic                  Bus2IP_Clk,
  input logic                  Bus2IP_Resetn,
  motion_ipif_master_if.master bus
);

  localparam int unsigned      CNT_W    = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [0:31]         rsp_data_q, rsp_data_d;
  logic                rsp_error_q, rsp_error_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [0:31]         addr_q, addr_d;
  logic [0:31]         data_q, data_d;
  logic [0:3]          be_q, be_d;
  logic                rnw_q, rnw_d;
  logic                cs_q, cs_d;
  logic [0:C_NUM_CE-1] rd_ce_q, rd_ce_d;
  logic [0:C_NUM_CE-1] wr_ce_q, wr_ce_d;

  logic [31:0]         idx_ext;
  logic                idx_bad;
  logic [31:0]         addr_calc;
  logic [0:C_NUM_CE-1] ce_onehot;
  logic                ack;

  // Decode the incoming command index: range check, address and one-hot CE.
  always_comb begin
    idx_ext   = 32'(bus.Cmd_Index);
    idx_bad   = (idx_ext >= C_NUM_CE);
    addr_calc = C_BASEADDR + (idx_ext << 2);
    ce_onehot = '0;
    for (int unsigned i = 0; i < C_NUM_CE; i++) begin
      ce_onehot[i] = (idx_ext == i);
    end
  end

  // Next-state and next-output computation; every output is a flop.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    busy_d        = busy_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = '0;
    rsp_error_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    addr_d        = addr_q;
    data_d        = data_q;
    be_d          = be_q;
    rnw_d         = rnw_q;
    cs_d          = cs_q;
    rd_ce_d       = rd_ce_q;
    wr_ce_d       = wr_ce_q;
    ack           = rnw_q ? bus.IP2Bus_RdAck : bus.IP2Bus_WrAck;

    case (state_q)
      ST_IDLE: begin
        if (bus.Cmd_Valid) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = '0;
          if (idx_bad) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            cs_d    = 1'b1;
            addr_d  = addr_calc;
            data_d  = bus.Cmd_Data;
            be_d    = bus.Cmd_BE;
            rnw_d   = bus.Cmd_RNW;
            rd_ce_d = bus.Cmd_RNW ? ce_onehot : '0;
            wr_ce_d = bus.Cmd_RNW ? '0 : ce_onehot;
          end
        end
      end

      ST_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An ack coinciding with counter expiry takes priority over the timeout.
        if (ack || (cnt_q == CNT_LAST)) begin
          state_d     = ST_RESP;
          cs_d        = 1'b0;
          rd_ce_d     = '0;
          wr_ce_d     = '0;
          rsp_valid_d = 1'b1;
          if (ack) begin
            rsp_error_d = bus.IP2Bus_Error;
            rsp_data_d  = (rnw_q && !bus.IP2Bus_Error) ? bus.IP2Bus_Data : '0;
          end else begin
            rsp_error_d   = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        cnt_d       = '0;
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        cs_d        = 1'b0;
        rd_ce_d     = '0;
        wr_ce_d     = '0;
        cnt_d       = '0;
      end
    endcase
  end

  // State and output registers; reset drops CE/CS at once and discards the command.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      be_q          <= '0;
      rnw_q         <= 1'b0;
      cs_q          <= 1'b0;
      rd_ce_q       <= '0;
      wr_ce_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      be_q          <= be_d;
      rnw_q         <= rnw_d;
      cs_q          <= cs_d;
      rd_ce_q       <= rd_ce_d;
      wr_ce_q       <= wr_ce_d;
    end
  end

  assign bus.Cmd_Ready    = cmd_ready_q;
  assign bus.Busy         = busy_q;
  assign bus.Rsp_Valid    = rsp_valid_q;
  assign bus.Rsp_Data     = rsp_data_q;
  assign bus.Rsp_Error    = rsp_error_q;
  assign bus.Rsp_Timeout  = rsp_timeout_q;
  assign bus.Bus2IP_Addr  = addr_q;
  assign bus.Bus2IP_CS    = cs_q;
  assign bus.Bus2IP_RNW   = rnw_q;
  assign bus.Bus2IP_Data  = data_q;
  assign bus.Bus2IP_BE    = be_q;
  assign bus.Bus2IP_RdCE  = rd_ce_q;
  assign bus.Bus2IP_WrCE  = wr_ce_q;

endmodule

// File: tb/tb_motion_ipif_master.sv
// Self-checking bench for motion_ipif_master (C_NUM_CE=32, C_IDX_W=6, C_TIMEOUT=16).
module tb_motion_ipif_master;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] BASE    = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  motion_ipif_master_if #(.C_NUM_CE(32), .C_IDX_W(6)) bus ();

  motion_ipif_master #(
    .C_NUM_CE  (32),
    .C_IDX_W   (6),
    .C_BASEADDR(BASE),
    .C_TIMEOUT (TIMEOUT)
  ) dut (
    .Bus2IP_Clk   (clk),
    .Bus2IP_Resetn(rst_n),
    .bus          (bus)
  );

  // Observation of one command, gathered from the bus cycle by cycle.
  typedef struct {
    int          ce_cycles;
    logic [31:0] rd_ce;
    logic [31:0] wr_ce;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rnw;
    logic        stable;
    logic        cs_ok;
    logic        busy_ok;
    logic        rsp_seen;
    int          rsp_lat;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_to;
    logic        after_valid;
    logic [31:0] after_data;
    logic        after_ready;
  } obs_t;

  // Reference: what a command with a given slave behaviour must produce.
  // ack_dly = wait cycles before the slave acks (-1 = never).
  function automatic obs_t predict(input logic rnw, input logic [5:0] idx,
                                   input logic [31:0] wd, input logic [3:0] be,
                                   input int ack_dly, input logic serr,
                                   input logic [31:0] rd);
    obs_t        e;
    int          n;
    logic        to;
    logic [31:0] top;
    e = '{default: 0};
    e.stable      = 1'b1;
    e.cs_ok       = 1'b1;
    e.busy_ok     = 1'b1;
    e.rsp_seen    = 1'b1;
    e.after_ready = 1'b1;
    if (idx >= 32) begin
      e.rsp_err = 1'b1;
      return e;
    end
    to  = (ack_dly < 0) || (ack_dly >= TIMEOUT);
    n   = to ? TIMEOUT : ack_dly + 1;
    top = 32'h8000_0000;
    e.ce_cycles = n;
    e.rsp_lat   = n;
    if (rnw) e.rd_ce = top >> idx;
    else     e.wr_ce = top >> idx;
    e.addr     = BASE + 32'(idx) * 4;
    e.wdata    = wd;
    e.be       = be;
    e.rnw      = rnw;
    e.rsp_to   = to;
    e.rsp_err  = to || serr;
    e.rsp_data = (rnw && !e.rsp_err) ? rd : 32'h0;
    return e;
  endfunction

  // Issue one command and act as the slave; records what the bus did.
  task automatic do_access(input logic rnw, input logic [5:0] idx, input logic [31:0] wd,
                           input logic [3:0] be, input int ack_dly, input logic serr,
                           input logic [31:0] rd, input logic other_ack, output obs_t o);
    logic [31:0] ce_now;
    logic        first;
    o = '{default: 0};
    o.stable  = 1'b1;
    o.cs_ok   = 1'b1;
    o.busy_ok = 1'b1;
    first     = 1'b1;
    @(negedge clk);
    bus.Cmd_Valid = 1'b1;
    bus.Cmd_RNW   = rnw;
    bus.Cmd_Index = idx;
    bus.Cmd_Data  = wd;
    bus.Cmd_BE    = be;
    @(negedge clk);
    bus.Cmd_Valid = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ce_now = bus.Bus2IP_RdCE | bus.Bus2IP_WrCE;
      if (bus.Cmd_Ready !== 1'b0 || bus.Busy !== 1'b1) o.busy_ok = 1'b0;
      if (bus.Bus2IP_CS !== ((ce_now != 0) ? 1'b1 : 1'b0)) o.cs_ok = 1'b0;
      bus.IP2Bus_RdAck = 1'b0;
      bus.IP2Bus_WrAck = 1'b0;
      bus.IP2Bus_Error = 1'b0;
      bus.IP2Bus_Data  = $urandom();
      if (ce_now != 0) begin
        o.ce_cycles++;
        if (first) begin
          first   = 1'b0;
          o.rd_ce = bus.Bus2IP_RdCE;
          o.wr_ce = bus.Bus2IP_WrCE;
          o.addr  = bus.Bus2IP_Addr;
          o.wdata = bus.Bus2IP_Data;
          o.be    = bus.Bus2IP_BE;
          o.rnw   = bus.Bus2IP_RNW;
        end else if (bus.Bus2IP_RdCE !== o.rd_ce || bus.Bus2IP_WrCE !== o.wr_ce ||
                     bus.Bus2IP_Addr !== o.addr || bus.Bus2IP_Data !== o.wdata ||
                     bus.Bus2IP_BE !== o.be || bus.Bus2IP_RNW !== o.rnw) begin
          o.stable = 1'b0;
        end
        if (o.ce_cycles == ack_dly + 1) begin
          if (rnw) bus.IP2Bus_RdAck = 1'b1;
          else     bus.IP2Bus_WrAck = 1'b1;
          bus.IP2Bus_Error = serr;
          bus.IP2Bus_Data  = rd;
        end
        if (other_ack) begin
          if (rnw) bus.IP2Bus_WrAck = 1'b1;
          else     bus.IP2Bus_RdAck = 1'b1;
        end
      end
      if (bus.Rsp_Valid === 1'b1) begin
        o.rsp_seen = 1'b1;
        o.rsp_lat  = cyc;
        o.rsp_data = bus.Rsp_Data;
        o.rsp_err  = bus.Rsp_Error;
        o.rsp_to   = bus.Rsp_Timeout;
        break;
      end
      @(negedge clk);
    end
    bus.IP2Bus_RdAck = 1'b0;
    bus.IP2Bus_WrAck = 1'b0;
    bus.IP2Bus_Error = 1'b0;
    @(negedge clk);
    o.after_valid = bus.Rsp_Valid;
    o.after_data  = bus.Rsp_Data;
    o.after_ready = bus.Cmd_Ready;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if (bus.Cmd_Ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", bus.Cmd_Ready); end
    tests++; if ({bus.Busy, bus.Rsp_Valid, bus.Rsp_Error, bus.Rsp_Timeout, bus.Bus2IP_CS, bus.Bus2IP_RNW} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 000000",
                        {bus.Busy, bus.Rsp_Valid, bus.Rsp_Error, bus.Rsp_Timeout, bus.Bus2IP_CS, bus.Bus2IP_RNW}); end
    tests++; if ((bus.Bus2IP_RdCE | bus.Bus2IP_WrCE | bus.Bus2IP_Addr | bus.Bus2IP_Data | bus.Rsp_Data) !== 32'h0) begin
      fails++; $display("FAIL reset_vectors: got %h expected 0",
                        bus.Bus2IP_RdCE | bus.Bus2IP_WrCE | bus.Bus2IP_Addr | bus.Bus2IP_Data | bus.Rsp_Data); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_fast_ack();
    obs_t o;
    do_access(1'b0, 6'd6, 32'h20, 4'hF, 0, 1'b0, 32'h0, 1'b0, o);
    tests++; if (o.wr_ce !== 32'h0200_0000) begin fails++; $display("FAIL wr_ce: got %h expected 02000000", o.wr_ce); end
    tests++; if (o.rd_ce !== 32'h0) begin fails++; $display("FAIL wr_rd_ce: got %h expected 0", o.rd_ce); end
    tests++; if (o.ce_cycles !== 1) begin fails++; $display("FAIL wr_ce_cycles: got %0d expected 1", o.ce_cycles); end
    tests++; if (o.addr !== BASE + 32'h18) begin fails++; $display("FAIL wr_addr: got %h expected %h", o.addr, BASE + 32'h18); end
    tests++; if (o.wdata !== 32'h20 || o.be !== 4'hF) begin fails++; $display("FAIL wr_data_be: got %h/%h expected 00000020/f", o.wdata, o.be); end
    tests++; if (o.rsp_lat !== 1 || o.rsp_seen !== 1'b1) begin fails++; $display("FAIL wr_rsp_lat: got %0d seen %b expected 1", o.rsp_lat, o.rsp_seen); end
    tests++; if (o.rsp_err !== 1'b0) begin fails++; $display("FAIL wr_err: got %b expected 0", o.rsp_err); end
    tests++; if (o.after_valid !== 1'b0 || o.after_ready !== 1'b1) begin
      fails++; $display("FAIL wr_rsp_pulse: got valid %b ready %b expected 0 1", o.after_valid, o.after_ready); end
  endtask

  task automatic test_read_delayed();
    obs_t o;
    do_access(1'b1, 6'd19, 32'h1234_5678, 4'h3, 3, 1'b0, 32'hDEAD_BEEF, 1'b0, o);
    tests++; if (o.rd_ce !== 32'h0000_1000) begin fails++; $display("FAIL rd_ce: got %h expected 00001000", o.rd_ce); end
    tests++; if (o.ce_cycles !== 4) begin fails++; $display("FAIL rd_ce_cycles: got %0d expected 4", o.ce_cycles); end
    tests++; if (o.stable !== 1'b1 || o.cs_ok !== 1'b1) begin fails++; $display("FAIL rd_stable: got %b/%b expected 1/1", o.stable, o.cs_ok); end
    tests++; if (o.rsp_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data: got %h expected deadbeef", o.rsp_data); end
    tests++; if (o.rsp_err !== 1'b0) begin fails++; $display("FAIL rd_err: got %b expected 0", o.rsp_err); end
    tests++; if (o.after_data !== 32'h0) begin fails++; $display("FAIL rd_data_clear: got %h expected 0", o.after_data); end
  endtask

  task automatic test_timeout();
    obs_t o;
    do_access(1'b0, 6'd0, 32'hA5A5_0001, 4'h1, -1, 1'b0, 32'h0, 1'b0, o);
    tests++; if (o.wr_ce !== 32'h8000_0000) begin fails++; $display("FAIL to_ce: got %h expected 80000000", o.wr_ce); end
    tests++; if (o.ce_cycles !== TIMEOUT) begin fails++; $display("FAIL to_ce_cycles: got %0d expected %0d", o.ce_cycles, TIMEOUT); end
    tests++; if ({o.rsp_seen, o.rsp_err, o.rsp_to} !== 3'b111) begin fails++; $display("FAIL to_status: got %b expected 111", {o.rsp_seen, o.rsp_err, o.rsp_to}); end
    tests++; if (o.rsp_data !== 32'h0) begin fails++; $display("FAIL to_data: got %h expected 0", o.rsp_data); end
    // Ack landing on the last allowed cycle completes normally.
    do_access(1'b1, 6'd31, 32'h0, 4'hF, TIMEOUT - 1, 1'b0, 32'h0BAD_F00D, 1'b0, o);
    tests++; if (o.ce_cycles !== TIMEOUT) begin fails++; $display("FAIL edge_ce_cycles: got %0d expected %0d", o.ce_cycles, TIMEOUT); end
    tests++; if ({o.rsp_err, o.rsp_to} !== 2'b00 || o.rsp_data !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL edge_status: got %b data %h expected 00 0badf00d", {o.rsp_err, o.rsp_to}, o.rsp_data); end
  endtask

  task automatic test_read_error();
    obs_t o;
    do_access(1'b1, 6'd12, 32'h0, 4'hF, 1, 1'b1, 32'h7777_7777, 1'b1, o);
    tests++; if (o.ce_cycles !== 2) begin fails++; $display("FAIL err_ce_cycles: got %0d expected 2", o.ce_cycles); end
    tests++; if ({o.rsp_err, o.rsp_to} !== 2'b10) begin fails++; $display("FAIL err_status: got %b expected 10", {o.rsp_err, o.rsp_to}); end
    tests++; if (o.rsp_data !== 32'h0) begin fails++; $display("FAIL err_data: got %h expected 0", o.rsp_data); end
  endtask

  task automatic test_bad_index();
    obs_t o;
    do_access(1'b0, 6'd40, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'h0, 1'b0, o);
    tests++; if (o.ce_cycles !== 0 || o.cs_ok !== 1'b1) begin fails++; $display("FAIL bad_ce: got %0d cs_ok %b expected 0 1", o.ce_cycles, o.cs_ok); end
    tests++; if (o.rsp_lat !== 0 || o.rsp_seen !== 1'b1) begin fails++; $display("FAIL bad_lat: got %0d seen %b expected 0", o.rsp_lat, o.rsp_seen); end
    tests++; if ({o.rsp_err, o.rsp_to} !== 2'b10) begin fails++; $display("FAIL bad_status: got %b expected 10", {o.rsp_err, o.rsp_to}); end
  endtask

  task automatic test_stray_ack();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    bus.IP2Bus_RdAck = 1'b1;
    bus.IP2Bus_WrAck = 1'b1;
    bus.IP2Bus_Error = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.Rsp_Valid !== 1'b0 || bus.Busy !== 1'b0 || bus.Rsp_Data !== 32'h0) seen = 1'b1;
    end
    bus.IP2Bus_RdAck = 1'b0;
    bus.IP2Bus_WrAck = 1'b0;
    bus.IP2Bus_Error = 1'b0;
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL stray_ack: got reaction %b expected 0", seen); end
  endtask

  task automatic test_reset_mid_access();
    logic rsp_seen, ce_seen;
    rsp_seen = 1'b0;
    ce_seen  = 1'b0;
    @(negedge clk);
    bus.Cmd_Valid = 1'b1;
    bus.Cmd_RNW   = 1'b0;
    bus.Cmd_Index = 6'd9;
    @(negedge clk);
    bus.Cmd_Valid = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (bus.Bus2IP_WrCE !== 32'h0040_0000) begin fails++; $display("FAIL rst_pre_ce: got %h expected 00400000", bus.Bus2IP_WrCE); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ((bus.Bus2IP_WrCE | bus.Bus2IP_RdCE) !== 32'h0 || bus.Bus2IP_CS !== 1'b0) begin
      fails++; $display("FAIL rst_async_ce: got ce %h cs %b expected 0 0", bus.Bus2IP_WrCE | bus.Bus2IP_RdCE, bus.Bus2IP_CS); end
    tests++; if ({bus.Rsp_Valid, bus.Cmd_Ready, bus.Busy} !== 3'b010) begin
      fails++; $display("FAIL rst_async_flags: got %b expected 010", {bus.Rsp_Valid, bus.Cmd_Ready, bus.Busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.Rsp_Valid !== 1'b0) rsp_seen = 1'b1;
      if ((bus.Bus2IP_WrCE | bus.Bus2IP_RdCE) !== 32'h0) ce_seen = 1'b1;
    end
    tests++; if ({rsp_seen, ce_seen} !== 2'b00) begin fails++; $display("FAIL rst_discard: got rsp %b ce %b expected 0 0", rsp_seen, ce_seen); end
  endtask

  task automatic test_back_to_back();
    int   acc[$];
    int   last_hi;
    int   min_gap;
    logic ce_now, ce_prev;
    last_hi = -1;
    min_gap = 1000;
    ce_prev = 1'b0;
    @(negedge clk);
    bus.Cmd_Valid = 1'b1;
    for (int cyc = 0; cyc < 40 && acc.size() < 5; cyc++) begin
      ce_now = ((bus.Bus2IP_RdCE | bus.Bus2IP_WrCE) != 0);
      if (ce_now && !ce_prev && last_hi >= 0 && (cyc - last_hi - 1) < min_gap) min_gap = cyc - last_hi - 1;
      if (ce_now) last_hi = cyc;
      ce_prev = ce_now;
      bus.IP2Bus_RdAck = (bus.Bus2IP_RdCE != 0);
      bus.IP2Bus_WrAck = (bus.Bus2IP_WrCE != 0);
      if (bus.Cmd_Ready === 1'b1) acc.push_back(cyc);
      else begin
        bus.Cmd_RNW   = 1'($urandom_range(0, 1));
        bus.Cmd_Index = 6'($urandom_range(0, 31));
        bus.Cmd_Data  = $urandom();
      end
      @(negedge clk);
    end
    bus.Cmd_Valid = 1'b0;
    for (int cyc = 0; cyc < 40 && bus.Busy === 1'b1; cyc++) begin
      bus.IP2Bus_RdAck = (bus.Bus2IP_RdCE != 0);
      bus.IP2Bus_WrAck = (bus.Bus2IP_WrCE != 0);
      @(negedge clk);
    end
    bus.IP2Bus_RdAck = 1'b0;
    bus.IP2Bus_WrAck = 1'b0;
    tests++; if (acc.size() !== 5) begin fails++; $display("FAIL b2b_count: got %0d expected 5", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      tests++; if (acc[i] - acc[i-1] !== 3) begin fails++; $display("FAIL b2b_spacing[%0d]: got %0d expected 3", i, acc[i] - acc[i-1]); end
    end
    tests++; if (min_gap !== 2) begin fails++; $display("FAIL b2b_ce_gap: got %0d expected 2", min_gap); end
  endtask

  task automatic test_random();
    obs_t        o, e;
    logic        rnw, serr, oth;
    logic [5:0]  idx;
    logic [31:0] wd, rd;
    logic [3:0]  be;
    int          r, dly;
    for (int n = 0; n < 40; n++) begin
      rnw  = 1'($urandom_range(0, 1));
      idx  = 6'($urandom_range(0, 39));
      wd   = $urandom();
      rd   = $urandom();
      be   = 4'($urandom_range(0, 15));
      serr = ($urandom_range(0, 3) == 0);
      oth  = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 19);
      dly  = (r == 19) ? -1 : r;
      e = predict(rnw, idx, wd, be, dly, serr, rd);
      do_access(rnw, idx, wd, be, dly, serr, rd, oth, o);
      tests++; if (o.ce_cycles !== e.ce_cycles) begin fails++; $display("FAIL rnd%0d_ce_cycles: got %0d expected %0d", n, o.ce_cycles, e.ce_cycles); end
      tests++; if (o.rd_ce !== e.rd_ce || o.wr_ce !== e.wr_ce) begin
        fails++; $display("FAIL rnd%0d_ce: got %h/%h expected %h/%h", n, o.rd_ce, o.wr_ce, e.rd_ce, e.wr_ce); end
      tests++; if (o.addr !== e.addr || o.wdata !== e.wdata || o.be !== e.be || o.rnw !== e.rnw) begin
        fails++; $display("FAIL rnd%0d_bus: got %h %h %h %b expected %h %h %h %b", n, o.addr, o.wdata, o.be, o.rnw, e.addr, e.wdata, e.be, e.rnw); end
      tests++; if ({o.stable, o.cs_ok, o.busy_ok} !== {e.stable, e.cs_ok, e.busy_ok}) begin
        fails++; $display("FAIL rnd%0d_hold: got %b expected %b", n, {o.stable, o.cs_ok, o.busy_ok}, {e.stable, e.cs_ok, e.busy_ok}); end
      tests++; if (o.rsp_seen !== e.rsp_seen || o.rsp_lat !== e.rsp_lat) begin
        fails++; $display("FAIL rnd%0d_lat: got %b %0d expected %b %0d", n, o.rsp_seen, o.rsp_lat, e.rsp_seen, e.rsp_lat); end
      tests++; if ({o.rsp_err, o.rsp_to} !== {e.rsp_err, e.rsp_to} || o.rsp_data !== e.rsp_data) begin
        fails++; $display("FAIL rnd%0d_rsp: got %b %h expected %b %h", n, {o.rsp_err, o.rsp_to}, o.rsp_data, {e.rsp_err, e.rsp_to}, e.rsp_data); end
      tests++; if (o.after_valid !== e.after_valid || o.after_data !== e.after_data || o.after_ready !== e.after_ready) begin
        fails++; $display("FAIL rnd%0d_after: got %b %h %b expected %b %h %b", n, o.after_valid, o.after_data, o.after_ready,
                          e.after_valid, e.after_data, e.after_ready); end
    end
  endtask

  initial begin
    bus.Cmd_Valid    = 1'b0;
    bus.Cmd_RNW      = 1'b0;
    bus.Cmd_Index    = '0;
    bus.Cmd_Data     = '0;
    bus.Cmd_BE       = '0;
    bus.IP2Bus_Data  = '0;
    bus.IP2Bus_RdAck = 1'b0;
    bus.IP2Bus_WrAck = 1'b0;
    bus.IP2Bus_Error = 1'b0;
    test_reset();
    test_write_fast_ack();
    test_read_delayed();
    test_timeout();
    test_read_error();
    test_bad_index();
    test_stray_ack();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
